// File: rtl/cache_mem_arbiter.sv
// Two-port cache-to-memory arbiter: serialises icache/dcache word requests onto a
// single memory handshake, round-robin on conflict, with registered outputs throughout.
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_cache_req,
  input  logic [ADDR_W-1:0]   inst_cache_addr,
  output logic [DATA_W-1:0]   inst_cache_rdata,
  output logic                inst_cache_dok,
  input  logic                data_cache_req,
  input  logic [DATA_W/8-1:0] data_cache_wen,
  input  logic [ADDR_W-1:0]   data_cache_addr,
  input  logic [DATA_W-1:0]   data_cache_wdata,
  output logic [DATA_W-1:0]   data_cache_rdata,
  output logic                data_cache_dok,
  output logic                mem_req,
  output logic [DATA_W/8-1:0] mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, MEM_I, MEM_D, RESP} state_t;
  typedef enum logic {GRANT_INST, GRANT_DATA} grant_t;

  state_t            state_q, state_d;
  grant_t            last_q, last_d;
  logic              mem_req_q, mem_req_d;
  logic [BE_W-1:0]   mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic              inst_dok_q, inst_dok_d;
  logic              data_dok_q, data_dok_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    mem_req_d    = mem_req_q;
    mem_wen_d    = mem_wen_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_dok_d   = 1'b0;
    data_dok_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // Data wins when alone or when inst was the most recent winner.
        if (data_cache_req && (!inst_cache_req || last_q == GRANT_INST)) begin
          state_d     = MEM_D;
          last_d      = GRANT_DATA;
          mem_req_d   = 1'b1;
          mem_wen_d   = data_cache_wen;
          mem_addr_d  = data_cache_addr;
          mem_wdata_d = data_cache_wdata;
        end else if (inst_cache_req) begin
          state_d     = MEM_I;
          last_d      = GRANT_INST;
          mem_req_d   = 1'b1;
          mem_wen_d   = '0;
          mem_addr_d  = inst_cache_addr;
          mem_wdata_d = '0;
        end
      end
      MEM_I: begin
        if (mem_req_q && mem_ack) begin
          state_d      = RESP;
          mem_req_d    = 1'b0;
          inst_rdata_d = mem_rdata;
          inst_dok_d   = 1'b1;
        end
      end
      MEM_D: begin
        if (mem_req_q && mem_ack) begin
          state_d      = RESP;
          mem_req_d    = 1'b0;
          data_rdata_d = mem_rdata;
          data_dok_d   = 1'b1;
        end
      end
      RESP: begin
        // Requests are deliberately not sampled here so the cache can drop req.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      last_q       <= GRANT_INST;
      mem_req_q    <= 1'b0;
      mem_wen_q    <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_dok_q   <= 1'b0;
      data_dok_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      mem_req_q    <= mem_req_d;
      mem_wen_q    <= mem_wen_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_dok_q   <= inst_dok_d;
      data_dok_q   <= data_dok_d;
      busy_q       <= busy_d;
    end
  end

  assign mem_req          = mem_req_q;
  assign mem_wen          = mem_wen_q;
  assign mem_addr         = mem_addr_q;
  assign mem_wdata        = mem_wdata_q;
  assign inst_cache_rdata = inst_rdata_q;
  assign data_cache_rdata = data_rdata_q;
  assign inst_cache_dok   = inst_dok_q;
  assign data_cache_dok   = data_dok_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_cache_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_cache_req;
  logic [31:0] inst_cache_addr;
  logic [31:0] inst_cache_rdata;
  logic        inst_cache_dok;
  logic        data_cache_req;
  logic [3:0]  data_cache_wen;
  logic [31:0] data_cache_addr;
  logic [31:0] data_cache_wdata;
  logic [31:0] data_cache_rdata;
  logic        data_cache_dok;
  logic        mem_req;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .inst_cache_req   (inst_cache_req),
    .inst_cache_addr  (inst_cache_addr),
    .inst_cache_rdata (inst_cache_rdata),
    .inst_cache_dok   (inst_cache_dok),
    .data_cache_req   (data_cache_req),
    .data_cache_wen   (data_cache_wen),
    .data_cache_addr  (data_cache_addr),
    .data_cache_wdata (data_cache_wdata),
    .data_cache_rdata (data_cache_rdata),
    .data_cache_dok   (data_cache_dok),
    .mem_req          (mem_req),
    .mem_wen          (mem_wen),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .mem_ack          (mem_ack),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_grant(input string tag);
    int n;
    n = 0;
    while (!mem_req && n < 10) begin
      step();
      n++;
    end
    chk(tag, 64'(mem_req), 64'h1);
  endtask

  task automatic ack(input logic [31:0] rd);
    mem_ack   = 1'b1;
    mem_rdata = rd;
    step();
    mem_ack   = 1'b0;
    mem_rdata = 32'hDEAD_0000;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  initial begin
    // Test 1: reset with arbitrary inputs
    resetn           = 1'b0;
    inst_cache_req   = 1'b1;
    inst_cache_addr  = 32'h1234_5678;
    data_cache_req   = 1'b1;
    data_cache_wen   = 4'hF;
    data_cache_addr  = 32'h8765_4321;
    data_cache_wdata = 32'hFFFF_FFFF;
    mem_rdata        = 32'hCAFE_F00D;
    mem_ack          = 1'b1;
    step();
    step();
    chk("rst_mem_req", 64'(mem_req), 64'h0);
    chk("rst_mem_addr", 64'(mem_addr), 64'h0);
    chk("rst_mem_wen", 64'(mem_wen), 64'h0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'h0);
    chk("rst_inst_rdata", 64'(inst_cache_rdata), 64'h0);
    chk("rst_data_rdata", 64'(data_cache_rdata), 64'h0);
    chk("rst_doks", 64'({inst_cache_dok, data_cache_dok}), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    inst_cache_req = 1'b0;
    data_cache_req = 1'b0;
    mem_ack        = 1'b0;
    resetn         = 1'b1;
    step();
    chk("idle_mem_req", 64'(mem_req), 64'h0);
    chk("idle_busy", 64'(busy), 64'h0);

    // Test 2: icache read, ack two cycles after mem_req
    inst_cache_req  = 1'b1;
    inst_cache_addr = 32'h1FC0_0000;
    step();
    chk("ird_mem_req", 64'(mem_req), 64'h1);
    chk("ird_mem_addr", 64'(mem_addr), 64'h1FC0_0000);
    chk("ird_mem_wen", 64'(mem_wen), 64'h0);
    chk("ird_busy", 64'(busy), 64'h1);
    step();
    chk("ird_hold_req", 64'(mem_req), 64'h1);
    ack(32'h3C1D_BFC0);
    chk("ird_dok", 64'(inst_cache_dok), 64'h1);
    chk("ird_rdata", 64'(inst_cache_rdata), 64'h3C1D_BFC0);
    chk("ird_ddok", 64'(data_cache_dok), 64'h0);
    chk("ird_req_drop", 64'(mem_req), 64'h0);
    inst_cache_req = 1'b0;
    step();
    chk("ird_dok_end", 64'(inst_cache_dok), 64'h0);
    chk("ird_rdata_hold", 64'(inst_cache_rdata), 64'h3C1D_BFC0);
    chk("ird_busy_end", 64'(busy), 64'h0);

    // Stray ack while idle must be ignored
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
    chk("stray_ack_doks", 64'({inst_cache_dok, data_cache_dok}), 64'h0);
    chk("stray_ack_req", 64'(mem_req), 64'h0);

    // Test 3: dcache partial write
    data_cache_req   = 1'b1;
    data_cache_wen   = 4'b0011;
    data_cache_addr  = 32'h8000_1004;
    data_cache_wdata = 32'hAABB_CCDD;
    step();
    chk("dwr_mem_req", 64'(mem_req), 64'h1);
    chk("dwr_mem_addr", 64'(mem_addr), 64'h8000_1004);
    chk("dwr_mem_wen", 64'(mem_wen), 64'h3);
    chk("dwr_mem_wdata", 64'(mem_wdata), 64'hAABB_CCDD);
    data_cache_wdata = 32'h0;
    data_cache_wen   = 4'h0;
    step();
    chk("dwr_hold_wen", 64'(mem_wen), 64'h3);
    chk("dwr_hold_wdata", 64'(mem_wdata), 64'hAABB_CCDD);
    ack(32'h1234_5678);
    chk("dwr_dok", 64'(data_cache_dok), 64'h1);
    chk("dwr_rdata", 64'(data_cache_rdata), 64'h1234_5678);
    chk("dwr_idok", 64'(inst_cache_dok), 64'h0);
    data_cache_req = 1'b0;
    step();
    chk("dwr_dok_end", 64'(data_cache_dok), 64'h0);

    // Test 4: conflict straight after reset, data wins
    do_reset();
    inst_cache_req  = 1'b1;
    inst_cache_addr = 32'h100;
    data_cache_req  = 1'b1;
    data_cache_wen  = 4'h0;
    data_cache_addr = 32'h200;
    step();
    chk("cf_first_addr", 64'(mem_addr), 64'h200);
    ack(32'hD000_0001);
    chk("cf_ddok", 64'(data_cache_dok), 64'h1);
    chk("cf_idok0", 64'(inst_cache_dok), 64'h0);
    chk("cf_drdata", 64'(data_cache_rdata), 64'hD000_0001);
    data_cache_req = 1'b0;
    step();
    chk("cf_resp_req", 64'(mem_req), 64'h0);
    step();
    chk("cf_second_req", 64'(mem_req), 64'h1);
    chk("cf_second_addr", 64'(mem_addr), 64'h100);
    ack(32'h1000_0002);
    chk("cf_idok", 64'(inst_cache_dok), 64'h1);
    chk("cf_ddok0", 64'(data_cache_dok), 64'h0);
    chk("cf_irdata", 64'(inst_cache_rdata), 64'h1000_0002);
    chk("cf_drdata_hold", 64'(data_cache_rdata), 64'hD000_0001);
    inst_cache_req = 1'b0;
    step();
    step();
    chk("cf_no_more", 64'({mem_req, inst_cache_dok, data_cache_dok}), 64'h0);

    // Test 5: persistent conflict alternates data, inst, data, inst
    inst_cache_req = 1'b1;
    data_cache_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_grant($sformatf("pc_grant%0d", i));
      chk($sformatf("pc_addr%0d", i), 64'(mem_addr), (i % 2 == 0) ? 64'h200 : 64'h100);
      ack(32'hA0 + 32'(i));
      chk($sformatf("pc_dok%0d", i), 64'({inst_cache_dok, data_cache_dok}),
          (i % 2 == 0) ? 64'h1 : 64'h2);
    end
    inst_cache_req = 1'b0;
    data_cache_req = 1'b0;
    step();
    step();
    chk("pc_idle", 64'(busy), 64'h0);

    // Test 6: reset while waiting in MEM_D
    data_cache_req  = 1'b1;
    data_cache_addr = 32'h300;
    step();
    chk("mr_req", 64'(mem_req), 64'h1);
    resetn = 1'b0;
    step();
    chk("mr_req_drop", 64'(mem_req), 64'h0);
    chk("mr_busy", 64'(busy), 64'h0);
    resetn         = 1'b1;
    data_cache_req = 1'b0;
    mem_ack        = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("mr_late_dok", 64'({inst_cache_dok, data_cache_dok}), 64'h0);
    step();
    chk("mr_late_dok2", 64'({inst_cache_dok, data_cache_dok}), 64'h0);
    chk("mr_idle_req", 64'(mem_req), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
